// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer with pause/resume, load clamping and a
// self-clearing alarm that lasts ALARM_TICKS ce ticks unless acknowledged.
module countdown_timer #(
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       ld,
    input  logic [7:0] d_min,
    input  logic [7:0] d_sec,
    input  logic       start,
    input  logic       pause,
    input  logic       ack,
    output logic [7:0] q_min,
    output logic [7:0] q_sec,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    localparam logic [7:0] TICK_LAST = 8'(ALARM_TICKS - 1);

    state_t      state, state_nx;
    logic [15:0] cnt_nx;
    logic [7:0]  tick, tick_nx;
    logic        done_nx;
    logic        cnt_zero;

    function automatic logic [7:0] clamp_bcd(input logic [7:0] d);
        logic [3:0] t, o;
        t = (d[7:4] > 4'd5) ? 4'd5 : d[7:4];
        o = (d[3:0] > 4'd9) ? 4'd9 : d[3:0];
        return {t, o};
    endfunction

    // One-second decrement with BCD borrow through all four digits; 00:00 holds.
    function automatic logic [15:0] dec_bcd(input logic [15:0] c);
        logic [3:0] m10, m1, s10, s1;
        {m10, m1, s10, s1} = c;
        if (c != 16'h0000) begin
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd9;
                if (s10 != 4'd0) begin
                    s10 = s10 - 4'd1;
                end else begin
                    s10 = 4'd5;
                    if (m1 != 4'd0) begin
                        m1 = m1 - 4'd1;
                    end else begin
                        m1  = 4'd9;
                        m10 = m10 - 4'd1;
                    end
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    assign cnt_zero = ({q_min, q_sec} == 16'h0000);

    always_comb begin
        state_nx = state;
        cnt_nx   = {q_min, q_sec};
        tick_nx  = tick;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !cnt_zero) begin
                    state_nx = RUN;
                end else if (ld) begin
                    cnt_nx = {clamp_bcd(d_min), clamp_bcd(d_sec)};
                end
            end
            RUN: begin
                if (ce) begin
                    cnt_nx = dec_bcd({q_min, q_sec});
                    // Expiry outranks a coincident pause.
                    if ({q_min, q_sec} == 16'h0001) begin
                        state_nx = ALARM;
                        tick_nx  = 8'd0;
                        done_nx  = 1'b1;
                    end else if (pause) begin
                        state_nx = PAUSE;
                    end
                end else if (pause) begin
                    state_nx = PAUSE;
                end
            end
            PAUSE: begin
                if (ack) begin
                    state_nx = IDLE;
                end else if (pause) begin
                    state_nx = PAUSE;
                end else if (start && !cnt_zero) begin
                    state_nx = RUN;
                end else if (ld) begin
                    cnt_nx = {clamp_bcd(d_min), clamp_bcd(d_sec)};
                end
            end
            ALARM: begin
                if (ack) begin
                    state_nx = IDLE;
                end else if (ce) begin
                    if (tick == TICK_LAST) state_nx = IDLE;
                    else                   tick_nx  = tick + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            q_min   <= 8'h00;
            q_sec   <= 8'h00;
            tick    <= 8'd0;
            running <= 1'b0;
            done    <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            state          <= state_nx;
            {q_min, q_sec} <= cnt_nx;
            tick           <= tick_nx;
            running        <= (state_nx == RUN);
            done           <= done_nx;
            alarm          <= (state_nx == ALARM);
        end
    end

endmodule
